// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the E stage.
//
// Holds the architectural HI/LO registers. A mult/multu/div/divu presented
// while idle computes its full 64-bit result at the start edge. The result
// is parked in res_hi/res_lo, and the unit then stays busy for a fixed
// latency before committing to HI/LO. mthi/mtlo write HI/LO directly when
// the unit is idle. mfhi/mflo read HI/LO through E_hiloData.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   E_mdOp     in   [3:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_A        in   [31:0] rs operand (forwarded)
//   E_B        in   [31:0] rt operand (forwarded)
//   busy       out         operation in progress (registered)
//   start      out         combinational: md op 1..4 accepted this cycle
//   hi, lo     out  [31:0] HI/LO registers
//   E_hiloData out  [31:0] hi for mfhi, lo for mflo, else 0
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  E_mdOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        busy,
    output logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] E_hiloData
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = ($clog2(MaxLat + 1) > 4) ? $clog2(MaxLat + 1) : 4;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       res_hi_q;
    logic [31:0]       res_lo_q;
    logic              div0_q;
    logic              busy_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    // -----------------------------------------------------------------------
    // Operation decode
    // -----------------------------------------------------------------------
    logic is_md_op;
    logic is_mult;

    assign is_md_op = (E_mdOp >= OpMult) && (E_mdOp <= OpDivu);
    assign is_mult  = (E_mdOp == OpMult) || (E_mdOp == OpMultu);
    assign start    = is_md_op && (state_q == StIdle);

    // -----------------------------------------------------------------------
    // Multiplier: both products are formed from 64-bit extended operands so
    // the low 64 bits of the product are exact for the signed and unsigned case.
    // -----------------------------------------------------------------------
    logic [63:0] a_sext;
    logic [63:0] b_sext;
    logic [63:0] a_zext;
    logic [63:0] b_zext;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign a_sext = {{32{E_A[31]}}, E_A};
    assign b_sext = {{32{E_B[31]}}, E_B};
    assign a_zext = {32'd0, E_A};
    assign b_zext = {32'd0, E_B};
    assign prod_s = a_sext * b_sext;
    assign prod_u = a_zext * b_zext;

    // -----------------------------------------------------------------------
    // Divider: one unsigned divider serves both div and divu. Signed division
    // runs on magnitudes and then fixes signs: the quotient is negated when the
    // operand signs differ, and the remainder takes the sign of the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    // -----------------------------------------------------------------------
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        div_by_zero;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [31:0] squo;
    logic [31:0] srem;

    assign div_signed  = (E_mdOp == OpDiv);
    assign a_neg       = div_signed && E_A[31];
    assign b_neg       = div_signed && E_B[31];
    assign div_by_zero = (E_B == 32'd0);
    assign dvd_mag     = a_neg ? (~E_A + 32'd1) : E_A;
    assign dvs_mag     = b_neg ? (~E_B + 32'd1) : E_B;
    // Keeps the divider result defined on a zero divisor; the result is
    // discarded anyway in that case.
    assign dvs_safe    = div_by_zero ? 32'd1 : dvs_mag;
    assign uquo        = dvd_mag / dvs_safe;
    assign urem        = dvd_mag % dvs_safe;
    assign squo        = (a_neg ^ b_neg) ? (~uquo + 32'd1) : uquo;
    assign srem        = a_neg ? (~urem + 32'd1) : urem;

    // -----------------------------------------------------------------------
    // Result select and latency for the operation being started
    // -----------------------------------------------------------------------
    logic [31:0]     res_hi_d;
    logic [31:0]     res_lo_d;
    logic            div0_d;
    logic [CntW-1:0] lat_d;

    always_comb begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        div0_d   = 1'b0;
        unique case (E_mdOp)
            OpMult: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OpMultu: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OpDiv: begin
                res_hi_d = srem;
                res_lo_d = squo;
                div0_d   = div_by_zero;
            end
            OpDivu: begin
                res_hi_d = urem;
                res_lo_d = uquo;
                div0_d   = div_by_zero;
            end
            default: begin
                res_hi_d = 32'd0;
                res_lo_d = 32'd0;
                div0_d   = 1'b0;
            end
        endcase
    end

    assign lat_d = is_mult ? CntW'(MULT_LAT) : CntW'(DIV_LAT);

    // -----------------------------------------------------------------------
    // Control FSM and HI/LO state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                        div0_q   <= div0_d;
                        cnt_q    <= lat_d;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else if (E_mdOp == OpMthi) begin
                        hi_q <= E_A;
                    end else if (E_mdOp == OpMtlo) begin
                        lo_q <= E_A;
                    end
                end
                StRun: begin
                    // Any op presented while running, including on the final
                    // edge, is ignored; the pipeline re-presents it once idle.
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        if (!div0_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // No bypass of an in-flight result: the hazard unit holds mfhi/mflo back
    // while busy.
    always_comb begin
        E_hiloData = 32'd0;
        if (E_mdOp == OpMfhi) begin
            E_hiloData = hi_q;
        end else if (E_mdOp == OpMflo) begin
            E_hiloData = lo_q;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
// Expected HI/LO values are queued when an operation is issued and popped and
// compared once busy falls.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int unsigned MultLat = 5;
    localparam int unsigned DivLat  = 10;

    logic        clk;
    logic        reset_n;
    logic [3:0]  E_mdOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        busy;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] E_hiloData;

    md_unit #(
        .MULT_LAT (MultLat),
        .DIV_LAT  (DivLat)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .E_mdOp     (E_mdOp),
        .E_A        (E_A),
        .E_B        (E_B),
        .busy       (busy),
        .start      (start),
        .hi         (hi),
        .lo         (lo),
        .E_hiloData (E_hiloData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Present an md op for one cycle and queue its expected HI/LO.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        E_mdOp = op;
        E_A    = a;
        E_B    = b;
        #1;
        check("start", {31'd0, start}, 32'd1);
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        @(posedge clk);
        #1;
        E_mdOp = 4'd0;
    endtask

    // One-cycle op with no busy phase (mthi/mtlo).
    task automatic single(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        E_mdOp = op;
        E_A    = a;
        @(posedge clk);
        #1;
        E_mdOp = 4'd0;
    endtask

    task automatic pop_and_compare(input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        if (exp_hi_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got hi=%h lo=%h", tag, hi, lo);
        end else begin
            eh = exp_hi_q.pop_front();
            el = exp_lo_q.pop_front();
            check({tag, "_hi"}, hi, eh);
            check({tag, "_lo"}, lo, el);
            model_hi = eh;
            model_lo = el;
        end
    endtask

    // Count busy cycles (plus any already counted) until busy drops, then
    // compare HI/LO against the scoreboard.
    task automatic wait_done(input string tag, input int lat, input int already);
        int n;
        n = already;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 200) break;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(lat));
        pop_and_compare(tag);
    endtask

    task automatic hilo_read(input string tag, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        E_mdOp = 4'd7;
        #1 check({tag, "_mfhi"}, E_hiloData, eh);
        E_mdOp = 4'd8;
        #1 check({tag, "_mflo"}, E_hiloData, el);
        E_mdOp = 4'd11;
        #1 check({tag, "_nop_read"}, E_hiloData, 32'd0);
        E_mdOp = 4'd0;
    endtask

    initial begin
        int pre;
        total    = 0;
        bad      = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset_n  = 1'b0;
        E_mdOp   = 4'd0;
        E_A      = 32'd0;
        E_B      = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // 1: signed mult
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_done("mult", MultLat, 0);
        hilo_read("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // 2: unsigned mult
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu", MultLat, 0);

        // 3: signed and unsigned divide, plus the overflow corner
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div", DivLat, 0);
        issue(4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        wait_done("divu", DivLat, 0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done("div_ovf", DivLat, 0);

        // 4: mthi then divide by zero keeps HI/LO
        single(4'd5, 32'h1234_5678);
        check("mthi", hi, 32'h1234_5678);
        model_hi = 32'h1234_5678;
        issue(4'd3, 32'd5, 32'd0, model_hi, model_lo);
        wait_done("div0", DivLat, 0);

        // 5: ops presented while running are ignored
        issue(4'd1, 32'd3, 32'd4, 32'd0, 32'd12);
        pre = 0;
        @(negedge clk);
        pre += int'(busy);
        E_mdOp = 4'd6;
        E_A    = 32'hDEAD_0000;
        #1 check("run_mtlo_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        pre += int'(busy);
        E_mdOp = 4'd1;
        E_A    = 32'd100;
        E_B    = 32'd100;
        #1 check("run_mult_start", {31'd0, start}, 32'd0);
        @(posedge clk);
        #1 E_mdOp = 4'd0;
        wait_done("run_ignore", MultLat, pre);
        single(4'd6, 32'hDEAD_0000);
        check("mtlo_after", lo, 32'hDEAD_0000);
        model_lo = 32'hDEAD_0000;

        // Op presented on the final RUN edge is ignored, then accepted next cycle
        issue(4'd1, 32'd2, 32'd2, 32'd0, 32'd4);
        pre = 0;
        repeat (MultLat) begin
            @(negedge clk);
            pre += int'(busy);
        end
        E_mdOp = 4'd6;
        E_A    = 32'h0000_BEEF;
        #1 check("last_edge_start", {31'd0, start}, 32'd0);
        @(posedge clk);
        #1;
        check("last_edge_busy_cycles", 32'(pre), 32'(MultLat));
        check("last_edge_busy_low", {31'd0, busy}, 32'd0);
        pop_and_compare("last_edge");
        @(posedge clk);
        #1 E_mdOp = 4'd0;
        check("last_edge_mtlo_next", lo, 32'h0000_BEEF);

        // 6: asynchronous reset mid-divide (cnt == 4)
        issue(4'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_hi", hi, 32'd0);
        check("async_lo", lo, 32'd0);
        if (exp_hi_q.size() > 0) begin
            void'(exp_hi_q.pop_front());
            void'(exp_lo_q.pop_front());
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        check("sb_empty", 32'(exp_hi_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined CPU.
- Produces and holds HI/LO, which the W-stage write-back select reads through the pipelined hiloData path for mfhi/mflo.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and exposes a busy flag that the hazard unit uses to stall later md-class instructions.
- Computation runs over a fixed, parameterised latency; results commit to HI/LO at the end of that latency.

Parameters:
MULT_LAT, 5, cycles busy is high after a mult/multu start (>=1)
DIV_LAT, 10, cycles busy is high after a div/divu start (>=1)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
E_mdOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
E_A  input  32  rs operand (forwarded)
E_B  input  32  rt operand (forwarded)
busy  output  1  operation in progress
start  output  1  combinational: E_mdOp in 1..4 and unit idle
hi  output  32  HI register
lo  output  32  LO register
E_hiloData  output  32  combinational: hi if E_mdOp==7, lo if E_mdOp==8, else 0

Behaviour:
- States: IDLE, RUN. Internal registers: cnt (4+ bits, wide enough for max(MULT_LAT, DIV_LAT)), resHi, resLo.
- Reset (reset_n low, asynchronous, any time including mid-RUN):
  - hi=0, lo=0, busy=0, state=IDLE, cnt=0, resHi=resLo=0.
  - Any in-flight result is discarded.
- IDLE, E_mdOp in 1..4 (start=1), at the clock edge:
  - Capture the result into resHi/resLo.
  - busy<=1, state<=RUN, cnt<=MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4).
- Arithmetic, computed from E_A/E_B at the start edge:
  - mult: signed 64-bit product, {resHi,resLo}.
  - multu: unsigned 64-bit product, {resHi,resLo}.
  - div: resLo=quotient truncated toward zero, resHi=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives resLo=0x80000000, resHi=0.
  - divu: unsigned quotient in resLo, remainder in resHi.
  - Divide by zero (E_B==0): no commit. hi/lo keep their old values, but busy still runs the full DIV_LAT cycles.
- RUN, each edge: cnt<=cnt-1. On the edge where cnt==1:
  - hi<=resHi, lo<=resLo (unless divide by zero).
  - busy<=0, state<=IDLE.
  - busy is high for exactly LAT cycles. New hi/lo are visible in the cycle busy first reads 0.
- mthi / mtlo in IDLE: hi<=E_A / lo<=E_A at the edge, 1-cycle effect, busy unaffected.
- Any op 1..6 while state==RUN is ignored; start=0 in RUN.
  - The hazard unit must stall when busy|start and E/D carries an md instruction. The unit does not rely on this for correctness, but must not corrupt state.
- mfhi/mflo: E_hiloData is pure combinational from the current hi/lo, with no internal bypass of an in-flight result. The stall guarantees mfhi/mflo never reach E while busy.
- Simultaneous last RUN edge and a new op presented: the new op is ignored that edge (state still RUN at sampling). It is accepted the following cycle.
- Ops 0 and 9-15: no state change.

Test Plan:
1. Reset, then mult with A=0xFFFFFFFE (-2), B=3 -> start=1 that cycle. busy=1 for exactly 5 cycles. Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA, and mfhi/mflo on E_hiloData return these values.
2. multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
3. div with A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following divu with A=7, B=2 gives lo=3, hi=1.
4. mthi A=0x12345678, then div by zero -> busy for 10 cycles; hi stays 0x12345678 and lo is unchanged.
5. During RUN of a mult, present mtlo A=0xDEAD0000 and then a second mult -> both are ignored, and only the first mult result commits. The same mtlo presented after busy falls writes lo=0xDEAD0000.
6. Assert reset_n low asynchronously mid-div (cnt=4) -> busy, hi and lo drop to 0 immediately without waiting for a clock edge, and no commit follows after release.
